ps2_kbd_ctrl: RTL and testbench

Sequencer and scan-code decoder behind the PS/2 keyboard receiver. It drains the receiver FIFO through the `ready`/`nextdata_n` handshake and folds `E0`/`F0` prefix bytes into single key events. It also tracks shift, caps-lock and the held key, and delivers decoded key events with ASCII to the VGA text/display logic.

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_scan_ascii.sv | 64 ++++++
 rtl/ps2_kbd_ctrl.sv | 117 +++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and scan-code constants for the PS/2 keyboard controller
package ps2_pkg;
  typedef enum logic {S_WAIT, S_POP} state_t;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
endpackage

// File: rtl/ps2_scan_ascii.sv
// ps2_scan_ascii: combinational set-2 scan code to ASCII ROM; letters follow shift^caps, symbols follow shift
module ps2_scan_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  logic [7:0]  letter;
  logic [15:0] sym;
  // lowercase letter for each alphabetic key, 0 otherwise
  always_comb begin
    case (code)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
  end
  // {unshifted, shifted} pair for digits, punctuation and whitespace keys
  always_comb begin
    case (code)
      8'h16: sym = {"1", "!"};
      8'h1E: sym = {"2", "@"};
      8'h26: sym = {"3", "#"};
      8'h25: sym = {"4", "$"};
      8'h2E: sym = {"5", "%"};
      8'h36: sym = {"6", "^"};
      8'h3D: sym = {"7", "&"};
      8'h3E: sym = {"8", "*"};
      8'h46: sym = {"9", "("};
      8'h45: sym = {"0", ")"};
      8'h4E: sym = {"-", "_"};
      8'h55: sym = {"=", "+"};
      8'h29: sym = {8'h20, 8'h20};
      8'h5A: sym = {8'h0D, 8'h0D};
      default: sym = 16'h0000;
    endcase
  end
  assign ascii = (letter != 8'h00) ? ((shift ^ caps) ? letter - 8'h20 : letter)
                                   : (shift ? sym[7:0] : sym[15:8]);
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: drains the PS/2 receiver FIFO and folds E0/F0 prefixes into decoded key events
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             shift,
  output logic             caps,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen
);
  state_t           state_q, state_d;
  logic             pop_n_q, pop_n_d;
  logic             ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic             lshift_q, lshift_d, rshift_q, rshift_d, caps_q, caps_d;
  logic [7:0]       held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             key_valid_q, key_valid_d, key_ext_q, key_ext_d;
  logic             key_break_q, key_break_d, key_repeat_q, key_repeat_d;
  logic [7:0]       key_code_q, key_code_d, key_ascii_q, key_ascii_d;
  logic             take, ev, is_mod, mk, rep;
  logic [7:0]       rom_ascii;
  // The byte is taken and decoded on the same edge so the event lines up with the pop cycle
  always_comb begin
    take         = state_q == S_WAIT && kbd_ready;
    ev           = take && kbd_data != SC_EXT && kbd_data != SC_BRK;
    is_mod       = !ext_pend_q && (kbd_data == SC_LSHIFT || kbd_data == SC_RSHIFT);
    mk           = !brk_pend_q;
    rep          = !is_mod && mk && kbd_data == held_q;
    state_d      = take ? S_POP : S_WAIT;
    pop_n_d      = !take;
    ext_pend_d   = take ? (kbd_data == SC_EXT || (kbd_data == SC_BRK && ext_pend_q)) : ext_pend_q;
    brk_pend_d   = take ? (kbd_data == SC_BRK || (kbd_data == SC_EXT && brk_pend_q)) : brk_pend_q;
    lshift_d     = (ev && !ext_pend_q && kbd_data == SC_LSHIFT) ? mk : lshift_q;
    rshift_d     = (ev && !ext_pend_q && kbd_data == SC_RSHIFT) ? mk : rshift_q;
    caps_d       = caps_q ^ (ev && mk && !ext_pend_q && kbd_data == SC_CAPS && held_q != SC_CAPS);
    held_d       = (ev && !is_mod) ? (mk ? kbd_data : (kbd_data == held_q ? 8'h00 : held_q)) : held_q;
    cnt_d        = cnt_q + CNT_W'(ev && !is_mod && mk && !rep);
    ovf_d        = ovf_q | kbd_overflow;
    key_valid_d  = ev;
    key_code_d   = ev ? kbd_data : key_code_q;
    key_ext_d    = ev ? ext_pend_q : key_ext_q;
    key_break_d  = ev ? brk_pend_q : key_break_q;
    key_repeat_d = ev ? rep : key_repeat_q;
  end
  ps2_scan_ascii u_rom (
    .code  (kbd_data),
    .shift (lshift_d | rshift_d),
    .caps  (caps_d),
    .ascii (rom_ascii)
  );
  assign key_ascii_d = ev ? ((ext_pend_q || brk_pend_q) ? 8'h00 : rom_ascii) : key_ascii_q;
  // Sequencer and all decoded state; pop strobe idles high
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_WAIT;
      pop_n_q      <= 1'b1;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      caps_q       <= 1'b0;
      held_q       <= 8'h00;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      key_repeat_q <= 1'b0;
      key_ascii_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      pop_n_q      <= pop_n_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      caps_q       <= caps_d;
      held_q       <= held_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      key_repeat_q <= key_repeat_d;
      key_ascii_q  <= key_ascii_d;
    end
  end
  assign kbd_nextdata_n = pop_n_q;
  assign key_valid      = key_valid_q;
  assign key_code       = key_code_q;
  assign key_ext        = key_ext_q;
  assign key_break      = key_break_q;
  assign key_repeat     = key_repeat_q;
  assign key_ascii      = key_ascii_q;
  assign shift          = lshift_q | rshift_q;
  assign caps           = caps_q;
  assign held_code      = held_q;
  assign press_cnt      = cnt_q;
  assign ovf_seen       = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed vector table plus randomized byte stream checked against a key-event model
module tb_ps2_kbd_ctrl;
  logic       clk, clrn, kbd_ready, kbd_overflow;
  logic [7:0] kbd_data;
  logic       kbd_nextdata_n, key_valid, key_ext, key_break, key_repeat, shift, caps, ovf_seen;
  logic [7:0] key_code, key_ascii, held_code, press_cnt;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [7:0] code;
    logic       ext, brk, rep;
    logic [7:0] ascii;
    logic       sh, cp;
    logic [7:0] held, cnt;
  } vec_t;

  localparam logic [7:0] LC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DC [12] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                     8'h46, 8'h45, 8'h4E, 8'h55};
  localparam logic [7:0] POOL [12] = '{8'h1C, 8'h32, 8'h16, 8'h1E, 8'h29, 8'h5A, 8'h4E, 8'h55,
                                       8'h21, 8'h75, 8'h45, 8'h3A};

  ps2_kbd_ctrl #(.CNT_W(8)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_break      (key_break),
    .key_repeat     (key_repeat),
    .key_ascii      (key_ascii),
    .shift          (shift),
    .caps           (caps),
    .held_code      (held_code),
    .press_cnt      (press_cnt),
    .ovf_seen       (ovf_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model state: pending prefixes, modifier keys, held key, press count
  logic       m_ext, m_brk, m_ls, m_rs, m_caps;
  logic [7:0] m_held, m_cnt;

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_held = 8'h00; m_cnt = 8'h00;
  endfunction

  function automatic logic [7:0] ascii_of(input logic [7:0] c, input logic s, input logic cp);
    string dn = "1234567890-=";
    string ds = "!@#$%^&*()_+";
    logic [7:0] a = 8'h00;
    for (int i = 0; i < 26; i++) if (c == LC[i]) a = (s ^ cp) ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 12; i++) if (c == DC[i]) a = s ? ds[i] : dn[i];
    if (c == 8'h29) a = 8'h20;
    if (c == 8'h5A) a = 8'h0D;
    return a;
  endfunction

  function automatic vec_t model_step(input logic [7:0] b);
    vec_t v = '{b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      logic is_mod, make;
      is_mod = !m_ext && (b == 8'h12 || b == 8'h59);
      make = !m_brk;
      v.ev = 1; v.code = b; v.ext = m_ext; v.brk = m_brk;
      v.rep = !is_mod && make && b == m_held;
      if (!m_ext && b == 8'h12) m_ls = make;
      if (!m_ext && b == 8'h59) m_rs = make;
      if (!m_ext && make && b == 8'h58 && m_held != 8'h58) m_caps = !m_caps;
      if (!is_mod && make && !v.rep) begin
        m_held = b;
        m_cnt = m_cnt + 8'd1;
      end
      if (!is_mod && !make && b == m_held) m_held = 8'h00;
      v.ascii = (m_ext || m_brk) ? 8'h00 : ascii_of(b, m_ls | m_rs, m_caps);
      m_ext = 0; m_brk = 0;
    end
    v.sh = m_ls | m_rs; v.cp = m_caps; v.held = m_held; v.cnt = m_cnt;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // present one byte at the FIFO head and check the pop cycle and the following idle cycle
  task automatic apply(input vec_t e);
    kbd_data = e.b;
    kbd_ready = 1;
    @(negedge clk);
    chk("pop_low", kbd_nextdata_n, 0);
    chk("key_valid", key_valid, e.ev);
    if (e.ev) begin
      chk("key_code", key_code, e.code);
      chk("key_ext", key_ext, e.ext);
      chk("key_break", key_break, e.brk);
      chk("key_repeat", key_repeat, e.rep);
      chk("key_ascii", key_ascii, e.ascii);
    end
    chk("shift", shift, e.sh);
    chk("caps", caps, e.cp);
    chk("held_code", held_code, e.held);
    chk("press_cnt", press_cnt, e.cnt);
    @(negedge clk);
    chk("pop_high", kbd_nextdata_n, 1);
    chk("valid_low", key_valid, 0);
    kbd_ready = 0;
  endtask

  task automatic idle(input int n);
    kbd_ready = 0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_no_pop", kbd_nextdata_n, 1);
      chk("idle_no_valid", key_valid, 0);
    end
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 9);
    logic [31:0] u = $urandom;
    if (r == 0) return 8'hE0;
    if (r == 1) return 8'hF0;
    if (r == 2) return u[0] ? 8'h12 : 8'h59;
    if (r == 3) return 8'h58;
    if (r == 4) return u[7:0];
    return POOL[$urandom_range(0, 11)];
  endfunction

  vec_t tbl [22];
  vec_t e;

  initial begin
    tbl[0]  = '{8'h1C, 1, 8'h1C, 0, 0, 0, 8'h61, 0, 0, 8'h1C, 8'h01};
    tbl[1]  = '{8'h1C, 1, 8'h1C, 0, 0, 1, 8'h61, 0, 0, 8'h1C, 8'h01};
    tbl[2]  = '{8'hF0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h1C, 8'h01};
    tbl[3]  = '{8'h1C, 1, 8'h1C, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8'h01};
    tbl[4]  = '{8'h12, 1, 8'h12, 0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h01};
    tbl[5]  = '{8'h16, 1, 8'h16, 0, 0, 0, 8'h21, 1, 0, 8'h16, 8'h02};
    tbl[6]  = '{8'hF0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 8'h16, 8'h02};
    tbl[7]  = '{8'h12, 1, 8'h12, 0, 1, 0, 8'h00, 0, 0, 8'h16, 8'h02};
    tbl[8]  = '{8'h58, 1, 8'h58, 0, 0, 0, 8'h00, 0, 1, 8'h58, 8'h03};
    tbl[9]  = '{8'hF0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 8'h58, 8'h03};
    tbl[10] = '{8'h58, 1, 8'h58, 0, 1, 0, 8'h00, 0, 1, 8'h00, 8'h03};
    tbl[11] = '{8'h1C, 1, 8'h1C, 0, 0, 0, 8'h41, 0, 1, 8'h1C, 8'h04};
    tbl[12] = '{8'h58, 1, 8'h58, 0, 0, 0, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[13] = '{8'h58, 1, 8'h58, 0, 0, 1, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[14] = '{8'hE0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[15] = '{8'hF0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[16] = '{8'h75, 1, 8'h75, 1, 1, 0, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[17] = '{8'hE0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[18] = '{8'hE0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h58, 8'h05};
    tbl[19] = '{8'h1C, 1, 8'h1C, 1, 0, 0, 8'h00, 0, 0, 8'h1C, 8'h06};
    tbl[20] = '{8'h29, 1, 8'h29, 0, 0, 0, 8'h20, 0, 0, 8'h29, 8'h07};
    tbl[21] = '{8'h5A, 1, 8'h5A, 0, 0, 0, 8'h0D, 0, 0, 8'h5A, 8'h08};

    clrn = 0; kbd_ready = 0; kbd_data = 8'h00; kbd_overflow = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_pop_n", kbd_nextdata_n, 1);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ascii", key_ascii, 0);
    chk("rst_shift", shift, 0);
    chk("rst_caps", caps, 0);
    chk("rst_held", held_code, 0);
    chk("rst_cnt", press_cnt, 0);
    chk("rst_ovf", ovf_seen, 0);
    clrn = 1;
    idle(2);

    for (int i = 0; i < 22; i++) begin
      e = model_step(tbl[i].b);
      apply(tbl[i]);
    end

    for (int i = 0; i < 600; i++) begin
      e = model_step(pick());
      apply(e);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    for (int i = 0; i < 260; i++) begin
      e = model_step(i[0] ? 8'h1C : 8'h32);
      apply(e);
    end

    kbd_overflow = 1;
    @(negedge clk);
    kbd_overflow = 0;
    idle(3);
    chk("ovf_sticky", ovf_seen, 1);

    kbd_data = 8'hE0;
    kbd_ready = 1;
    @(posedge clk);
    #2;
    chk("pop_before_rst", kbd_nextdata_n, 0);
    clrn = 0;
    #1;
    chk("rst_pop_n_async", kbd_nextdata_n, 1);
    chk("rst_held_async", held_code, 0);
    chk("rst_cnt_async", press_cnt, 0);
    chk("rst_ovf_async", ovf_seen, 0);
    chk("rst_code_async", key_code, 0);
    kbd_ready = 0;
    @(negedge clk);
    clrn = 1;
    model_reset();
    e = model_step(8'h1C);
    apply(e);
    chk("post_rst_ext", key_ext, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
